// File: rtl/mac_job_sched.sv
// mac_job_sched: sequences one MAC job -- fetches activation vectors from memory,
// issues them to the MAC core under valid/ready, and writes every returned
// accumulator vector to consecutive result addresses.
// Optional build macro MAC_JOB_SCHED_PERF_EN adds the perf_busy_o / perf_stall_o
// cycle counters.
module mac_job_sched #(
    parameter int NUM_IN   = 128,
    parameter int IN_BITS  = 5,
    parameter int NUM_OUT  = 32,
    parameter int ACC_BITS = 7,
    parameter int ADDR_W   = 10
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         start_i,
    input  logic [ADDR_W-1:0]            num_vec_i,
    input  logic [ADDR_W-1:0]            act_base_i,
    input  logic [ADDR_W-1:0]            res_base_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         act_rd_en_o,
    output logic [ADDR_W-1:0]            act_rd_addr_o,
    input  logic [NUM_IN*IN_BITS-1:0]    act_rd_data_i,
    output logic                         mac_valid_o,
    input  logic                         mac_ready_i,
    output logic [NUM_IN*IN_BITS-1:0]    mac_data_o,
    input  logic                         acc_valid_i,
    input  logic [NUM_OUT*ACC_BITS-1:0]  acc_data_i,
    output logic                         res_wr_en_o,
    output logic [ADDR_W-1:0]            res_wr_addr_o,
    output logic [NUM_OUT*ACC_BITS-1:0]  res_wr_data_o
`ifdef MAC_JOB_SCHED_PERF_EN
    ,
    output logic [31:0]                  perf_busy_o,
    output logic [31:0]                  perf_stall_o
`endif
);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, ISSUE, DRAIN, DONE} state_t;

    state_t                        state, state_nx;
    logic [ADDR_W-1:0]             num_vec, act_base, res_base;
    logic [ADDR_W-1:0]             issue_cnt, res_cnt;
    logic [ADDR_W:0]               issue_nxt;
    logic [NUM_IN*IN_BITS-1:0]     hold_p0;
    logic                          vld_p1;
    logic [ADDR_W-1:0]             res_addr_p1;
    logic [NUM_OUT*ACC_BITS-1:0]   res_data_p1;
    logic                          start_ok, issue_hs, acc_take, job_active;

    assign start_ok   = (state == IDLE) && start_i;
    assign issue_hs   = (state == ISSUE) && mac_ready_i;
    assign job_active = (state == FETCH) || (state == WAIT) ||
                        (state == ISSUE) || (state == DRAIN);
    // Results beyond the job length, or outside a job, are dropped.
    assign acc_take   = acc_valid_i && job_active && (res_cnt != num_vec);
    // One bit wider so the last-vector test cannot wrap at 2^ADDR_W.
    assign issue_nxt  = {1'b0, issue_cnt} + {{ADDR_W{1'b0}}, 1'b1};

    // State register.
    always_ff @(posedge clk) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_nx      = state;
        busy_o        = (state != IDLE);
        done_o        = 1'b0;
        act_rd_en_o   = 1'b0;
        act_rd_addr_o = '0;
        mac_valid_o   = 1'b0;
        case (state)
            IDLE:  if (start_i) state_nx = (num_vec_i != '0) ? FETCH : DONE;
            FETCH: begin
                act_rd_en_o   = 1'b1;
                act_rd_addr_o = act_base + issue_cnt;
                state_nx      = WAIT;
            end
            WAIT:  state_nx = ISSUE;
            ISSUE: begin
                mac_valid_o = 1'b1;
                if (mac_ready_i)
                    state_nx = (issue_nxt < {1'b0, num_vec}) ? FETCH : DRAIN;
            end
            DRAIN: if (res_cnt == num_vec) state_nx = DONE;
            DONE: begin
                done_o   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Job parameters, counters, activation holding register and result write stage.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            num_vec     <= '0;
            act_base    <= '0;
            res_base    <= '0;
            issue_cnt   <= '0;
            res_cnt     <= '0;
            hold_p0     <= '0;
            vld_p1      <= 1'b0;
            res_addr_p1 <= '0;
            res_data_p1 <= '0;
        end else begin
            if (start_ok) begin
                num_vec   <= num_vec_i;
                act_base  <= act_base_i;
                res_base  <= res_base_i;
                issue_cnt <= '0;
                res_cnt   <= '0;
            end
            if (state == WAIT) hold_p0 <= act_rd_data_i;
            if (issue_hs)      issue_cnt <= issue_cnt + 1'b1;
            vld_p1 <= acc_take;
            if (acc_take) begin
                res_addr_p1 <= res_base + res_cnt;
                res_data_p1 <= acc_data_i;
                res_cnt     <= res_cnt + 1'b1;
            end
        end
    end

    assign mac_data_o    = hold_p0;
    assign res_wr_en_o   = vld_p1;
    assign res_wr_addr_o = res_addr_p1;
    assign res_wr_data_o = res_data_p1;

`ifdef MAC_JOB_SCHED_PERF_EN
    logic [31:0] perf_busy, perf_stall;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    // Busy and stall cycle counters, restarted by each accepted job.
    always_ff @(posedge clk) begin
        if (!nrst || start_ok) begin
            perf_busy  <= '0;
            perf_stall <= '0;
        end else begin
            if (busy_o)                           perf_busy  <= sat_inc(perf_busy);
            if ((state == ISSUE) && !mac_ready_i) perf_stall <= sat_inc(perf_stall);
        end
    end

    assign perf_busy_o  = perf_busy;
    assign perf_stall_o = perf_stall;
`endif

endmodule

// File: tb/tb_mac_job_sched.sv
// Directed self-checking bench for mac_job_sched with an activation memory model
// and a fixed-latency MAC model.
`define CHK(tag, o, e) chk(tag, 1024'(o), 1024'(e))

module tb_mac_job_sched;

    localparam int AW = 10;
    localparam int DW = 128 * 5;
    localparam int RW = 32 * 7;

    logic          clk = 1'b0;
    logic          nrst;
    logic          start_i;
    logic [AW-1:0] num_vec_i, act_base_i, res_base_i;
    logic          busy_o, done_o;
    logic          act_rd_en_o;
    logic [AW-1:0] act_rd_addr_o;
    logic [DW-1:0] act_rd_data_i = '0;
    logic          mac_valid_o, mac_ready_i;
    logic [DW-1:0] mac_data_o;
    logic          acc_valid_i;
    logic [RW-1:0] acc_data_i;
    logic          res_wr_en_o;
    logic [AW-1:0] res_wr_addr_o;
    logic [RW-1:0] res_wr_data_o;
`ifdef MAC_JOB_SCHED_PERF_EN
    logic [31:0]   perf_busy_o, perf_stall_o;
`endif

    mac_job_sched dut (
        .clk(clk), .nrst(nrst), .start_i(start_i), .num_vec_i(num_vec_i),
        .act_base_i(act_base_i), .res_base_i(res_base_i), .busy_o(busy_o),
        .done_o(done_o), .act_rd_en_o(act_rd_en_o), .act_rd_addr_o(act_rd_addr_o),
        .act_rd_data_i(act_rd_data_i), .mac_valid_o(mac_valid_o),
        .mac_ready_i(mac_ready_i), .mac_data_o(mac_data_o), .acc_valid_i(acc_valid_i),
        .acc_data_i(acc_data_i), .res_wr_en_o(res_wr_en_o),
        .res_wr_addr_o(res_wr_addr_o), .res_wr_data_o(res_wr_data_o)
`ifdef MAC_JOB_SCHED_PERF_EN
        , .perf_busy_o(perf_busy_o), .perf_stall_o(perf_stall_o)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] act_pat(input logic [AW-1:0] a);
        return {20{32'hA500_0000 | 32'(a)}};
    endfunction

    function automatic logic [RW-1:0] acc_pat(input logic [AW-1:0] a);
        return {7{32'hC300_0000 | 32'(a)}};
    endfunction

    // Activation memory: data one cycle after the read enable.
    always @(posedge clk)
        act_rd_data_i <= act_rd_en_o ? act_pat(act_rd_addr_o) : '0;

    // MAC core model: result returns a fixed number of cycles after each issue,
    // tagged with the activation address carried in the issued data.
    logic [5:0]    d_vld = '0;
    logic [AW-1:0] d_tag [6];
    logic          man_vld = 1'b0;
    logic [RW-1:0] man_data = '0;

    always @(posedge clk) begin
        d_vld    <= {d_vld[4:0], mac_valid_o && mac_ready_i};
        d_tag[0] <= mac_data_o[AW-1:0];
        for (int i = 1; i < 6; i++) d_tag[i] <= d_tag[i-1];
    end

    always_comb begin
        acc_valid_i = d_vld[5] | man_vld;
        acc_data_i  = d_vld[5] ? acc_pat(d_tag[5]) : man_data;
    end

    // Transaction monitor.
    int            rd_n = 0, wr_n = 0, done_n = 0, iss_n = 0;
    logic [AW-1:0] rd_log [64];
    logic [AW-1:0] wa_log [64];
    logic [RW-1:0] wd_log [64];

    always @(negedge clk) begin
        if (act_rd_en_o) begin rd_log[rd_n % 64] <= act_rd_addr_o; rd_n <= rd_n + 1; end
        if (res_wr_en_o) begin
            wa_log[wr_n % 64] <= res_wr_addr_o;
            wd_log[wr_n % 64] <= res_wr_data_o;
            wr_n <= wr_n + 1;
        end
        if (done_o) done_n <= done_n + 1;
        if (mac_valid_o && mac_ready_i) iss_n <= iss_n + 1;
    end

    int checks = 0;
    int errors = 0;

    // Protocol monitor.
    always @(negedge clk) begin
        if ((done_o === 1'b1) && (busy_o !== 1'b1)) begin
            checks++;
            errors++;
            $error("FAIL mon_done_not_busy");
        end
        if ((act_rd_en_o === 1'b1) && (mac_valid_o === 1'b1)) begin
            checks++;
            errors++;
            $error("FAIL mon_fetch_issue_overlap");
        end
        if ((mac_valid_o === 1'b1) && (busy_o === 1'b0)) begin
            checks++;
            errors++;
            $error("FAIL mon_issue_idle");
        end
    end

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_o !== 1'b1 && n < budget) begin
            cyc();
            n++;
        end
        `CHK(tag, n < budget, 1);
    endtask

    task automatic chk_zero(input string tag);
        `CHK({tag, "_busy"}, busy_o, 0);
        `CHK({tag, "_done"}, done_o, 0);
        `CHK({tag, "_rden"}, act_rd_en_o, 0);
        `CHK({tag, "_rdaddr"}, act_rd_addr_o, 0);
        `CHK({tag, "_mvalid"}, mac_valid_o, 0);
        `CHK({tag, "_mdata"}, mac_data_o, 0);
        `CHK({tag, "_wren"}, res_wr_en_o, 0);
        `CHK({tag, "_wraddr"}, res_wr_addr_o, 0);
        `CHK({tag, "_wrdata"}, res_wr_data_o, 0);
    endtask

    task automatic go(input logic [AW-1:0] nv, input logic [AW-1:0] ab, input logic [AW-1:0] rb);
        num_vec_i  = nv;
        act_base_i = ab;
        res_base_i = rb;
        start_i    = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, w0, d0, i0;
        nrst = 1'b0; start_i = 1'b0; num_vec_i = '0; act_base_i = '0; res_base_i = '0;
        mac_ready_i = 1'b1;
        repeat (3) cyc();
        chk_zero("reset");
        nrst = 1'b1;
        cyc();

        // Three-vector job, ready always high.
        r0 = rd_n; w0 = wr_n; d0 = done_n; i0 = iss_n;
        go(3, 10'h010, 10'h020);
        cyc();
        start_i = 1'b0;
        `CHK("a_rden_t1", act_rd_en_o, 1);
        `CHK("a_rdaddr_t1", act_rd_addr_o, 10'h010);
        `CHK("a_busy_t1", busy_o, 1);
        `CHK("a_mvalid_t1", mac_valid_o, 0);
        cyc();
        `CHK("a_rden_t2", act_rd_en_o, 0);
        `CHK("a_mvalid_t2", mac_valid_o, 0);
        cyc();
        `CHK("a_mvalid_t3", mac_valid_o, 1);
        `CHK("a_mdata_t3", mac_data_o, act_pat(10'h010));
        wait_done("a_done_seen", 100);
        cyc(); cyc();
        `CHK("a_busy_end", busy_o, 0);
        `CHK("a_nrd", rd_n - r0, 3);
        for (int k = 0; k < 3; k++) begin
            `CHK("a_rd_addr", rd_log[(r0 + k) % 64], 10'h010 + k);
            `CHK("a_wr_addr", wa_log[(w0 + k) % 64], 10'h020 + k);
            `CHK("a_wr_data", wd_log[(w0 + k) % 64], acc_pat(10'(10'h010 + k)));
        end
        `CHK("a_nwr", wr_n - w0, 3);
        `CHK("a_niss", iss_n - i0, 3);
        `CHK("a_ndone", done_n - d0, 1);

        // Zero-length job.
        r0 = rd_n; w0 = wr_n; d0 = done_n; i0 = iss_n;
        go(0, 10'h055, 10'h066);
        cyc();
        start_i = 1'b0;
        `CHK("b_done_t1", done_o, 1);
        `CHK("b_busy_t1", busy_o, 1);
        `CHK("b_rden_t1", act_rd_en_o, 0);
        cyc();
        `CHK("b_done_t2", done_o, 0);
        `CHK("b_busy_t2", busy_o, 0);
        repeat (3) cyc();
        `CHK("b_nrd", rd_n - r0, 0);
        `CHK("b_nwr", wr_n - w0, 0);
        `CHK("b_niss", iss_n - i0, 0);
        `CHK("b_ndone", done_n - d0, 1);

        // Backpressure in ISSUE, stray start during ISSUE, stray result in IDLE.
        r0 = rd_n; w0 = wr_n; d0 = done_n; i0 = iss_n;
        go(1, 10'h040, 10'h050);
        cyc();
        start_i = 1'b0;
        mac_ready_i = 1'b0;
        cyc(); cyc();
        for (int k = 0; k < 5; k++) begin
            `CHK("c_mvalid_stall", mac_valid_o, 1);
            `CHK("c_mdata_stall", mac_data_o, act_pat(10'h040));
            if (k == 0) go(5, 10'h300, 10'h310);
            cyc();
            start_i = 1'b0;
        end
        `CHK("c_mvalid_rel", mac_valid_o, 1);
        mac_ready_i = 1'b1;
        wait_done("c_done_seen", 100);
        cyc(); cyc();
`ifdef MAC_JOB_SCHED_PERF_EN
        `CHK("c_perf_stall", perf_stall_o, 5);
        `CHK("c_perf_busy", perf_busy_o, 16);
`endif
        `CHK("c_nrd", rd_n - r0, 1);
        `CHK("c_niss", iss_n - i0, 1);
        `CHK("c_nwr", wr_n - w0, 1);
        `CHK("c_wr_addr", wa_log[w0 % 64], 10'h050);
        `CHK("c_wr_data", wd_log[w0 % 64], acc_pat(10'h040));
        `CHK("c_ndone", done_n - d0, 1);
        man_data = acc_pat(10'h077);
        man_vld  = 1'b1;
        cyc();
        man_vld  = 1'b0;
        `CHK("c_idle_wren1", res_wr_en_o, 0);
        cyc();
        `CHK("c_idle_wren2", res_wr_en_o, 0);
        `CHK("c_idle_nwr", wr_n - w0, 1);

        // Address wrap on both read and write sides.
        r0 = rd_n; w0 = wr_n;
        go(2, 10'h3FF, 10'h3FF);
        cyc();
        start_i = 1'b0;
        `CHK("d_rdaddr_t1", act_rd_addr_o, 10'h3FF);
        wait_done("d_done_seen", 100);
        cyc(); cyc();
        `CHK("d_nrd", rd_n - r0, 2);
        `CHK("d_rd0", rd_log[r0 % 64], 10'h3FF);
        `CHK("d_rd1", rd_log[(r0 + 1) % 64], 10'h000);
        `CHK("d_nwr", wr_n - w0, 2);
        `CHK("d_wa0", wa_log[w0 % 64], 10'h3FF);
        `CHK("d_wa1", wa_log[(w0 + 1) % 64], 10'h000);
        `CHK("d_wd0", wd_log[w0 % 64], acc_pat(10'h3FF));
        `CHK("d_wd1", wd_log[(w0 + 1) % 64], acc_pat(10'h000));

        // Reset while draining: job abandoned, late result dropped.
        w0 = wr_n; d0 = done_n;
        go(1, 10'h100, 10'h200);
        cyc();
        start_i = 1'b0;
        cyc(); cyc(); cyc();
        `CHK("e_drain_busy", busy_o, 1);
        `CHK("e_drain_mvalid", mac_valid_o, 0);
        `CHK("e_drain_rden", act_rd_en_o, 0);
        nrst = 1'b0;
        cyc();
        chk_zero("e_rst");
        nrst = 1'b1;
        repeat (10) cyc();
        `CHK("e_nwr", wr_n - w0, 0);
        `CHK("e_ndone", done_n - d0, 0);
        `CHK("e_busy", busy_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
